// File: rtl/width_adj_arbiter_pkg.sv
// width_adj_arbiter_pkg
// Shared helpers for the width-adjusting round-robin arbiter.
//   clog2_int : ceiling log2 of a positive integer (clog2_int(1) = 0)
//   max_int   : larger of two integers
// Both are constant functions, so they can size ports and localparams.
package width_adj_arbiter_pkg;

  function automatic int clog2_int(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/width_adj_arbiter_if.sv
// width_adj_arbiter_if
// Bundles every channel-side and output-side handshake signal of the
// arbiter.
//   input_valid    : per-channel word offered
//   input_ready    : per-channel word accepted this cycle (one-hot or zero)
//   input_data     : channel i at [i*WORD_WIDTH_IN +: WORD_WIDTH_IN]
//   output_valid   : output register holds a word
//   output_ready   : consumer accepts the output word
//   output_data    : adjusted word
//   output_channel : source channel of output_data
// Handshake: a word moves on any rising edge where its valid and ready are
// both high; a producer holds valid and data steady until that edge, and
// ready may change at any time without obligation.
// Modports: slave = arbiter side, master = producers/consumer side.
interface width_adj_arbiter_if
  import width_adj_arbiter_pkg::*;
#(
  parameter int CHANNEL_COUNT       = 4,
  parameter int WORD_WIDTH_IN       = 8,
  parameter int WORD_WIDTH_OUT      = 16,
  parameter int CHANNEL_INDEX_WIDTH = max_int(1, clog2_int(CHANNEL_COUNT))
);

  logic [CHANNEL_COUNT-1:0]               input_valid;
  logic [CHANNEL_COUNT-1:0]               input_ready;
  logic [CHANNEL_COUNT*WORD_WIDTH_IN-1:0] input_data;
  logic                                   output_valid;
  logic                                   output_ready;
  logic [WORD_WIDTH_OUT-1:0]              output_data;
  logic [CHANNEL_INDEX_WIDTH-1:0]         output_channel;

  modport slave (
    input  input_valid,
    input  input_data,
    input  output_ready,
    output input_ready,
    output output_valid,
    output output_data,
    output output_channel
  );

  modport master (
    output input_valid,
    output input_data,
    output output_ready,
    input  input_ready,
    input  output_valid,
    input  output_data,
    input  output_channel
  );

endinterface

// File: rtl/width_adj_arbiter_width_adj.sv
// width_adj
// Purely combinational width adjuster for one channel.
//   din  : WIDTH_IN-bit input word
//   dout : WIDTH_OUT-bit word; widened words are sign-extended when SIGNED
//          is set and zero-extended otherwise, equal widths pass through,
//          narrowed words keep only the low WIDTH_OUT bits.
module width_adj #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 16,
  parameter bit SIGNED    = 1'b0
) (
  input  logic [WIDTH_IN-1:0]  din,
  output logic [WIDTH_OUT-1:0] dout
);

  if (WIDTH_OUT > WIDTH_IN) begin : g_extend
    logic pad_bit;
    assign pad_bit = SIGNED ? din[WIDTH_IN-1] : 1'b0;
    assign dout    = {{(WIDTH_OUT - WIDTH_IN){pad_bit}}, din};
  end else begin : g_keep_low
    // Also covers the equal-width case, where this is a plain pass-through.
    assign dout = din[WIDTH_OUT-1:0];
  end

endmodule

// File: rtl/width_adj_arbiter.sv
// width_adj_arbiter
// Round-robin arbiter feeding one registered, width-adjusted output stream.
// Ports:
//   clock : single clock, rising edge
//   clear : synchronous active-high reset
//   bus   : width_adj_arbiter_if.slave (channel inputs, output stream)
// Each channel word is width-adjusted by its own width_adj instance; the
// rotating-priority scan picks one winner, whose adjusted word and index
// are loaded into the output register.
module width_adj_arbiter
  import width_adj_arbiter_pkg::*;
#(
  parameter int                     WORD_WIDTH_IN  = 8,
  parameter int                     WORD_WIDTH_OUT = 16,
  parameter int                     CHANNEL_COUNT  = 4,
  parameter logic [CHANNEL_COUNT-1:0] CHANNEL_SIGNED = '0
) (
  input logic                 clock,
  input logic                 clear,
  width_adj_arbiter_if.slave  bus
);

  localparam int CHANNEL_INDEX_WIDTH = max_int(1, clog2_int(CHANNEL_COUNT));

  // Per-channel adjusted words.
  logic [WORD_WIDTH_OUT-1:0] adjusted [CHANNEL_COUNT];

  for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_channel
    width_adj #(
      .WIDTH_IN  (WORD_WIDTH_IN),
      .WIDTH_OUT (WORD_WIDTH_OUT),
      .SIGNED    (CHANNEL_SIGNED[i])
    ) u_width_adj (
      .din  (bus.input_data[i*WORD_WIDTH_IN +: WORD_WIDTH_IN]),
      .dout (adjusted[i])
    );
  end

  // State: priority pointer and output register.
  logic [CHANNEL_INDEX_WIDTH-1:0] priority_ptr;
  logic                           out_valid_q;
  logic [WORD_WIDTH_OUT-1:0]      out_data_q;
  logic [CHANNEL_INDEX_WIDTH-1:0] out_channel_q;

  logic                           load_enable;
  logic                           grant_found;
  logic [CHANNEL_INDEX_WIDTH-1:0] grant_idx;
  logic [CHANNEL_INDEX_WIDTH-1:0] next_ptr;
  logic                           transfer;
  logic [CHANNEL_COUNT-1:0]       ready_vec;

  // The output register can take a new word when empty or being drained.
  assign load_enable = ~out_valid_q | bus.output_ready;

  // Rotating-priority scan: first valid channel at or above the pointer,
  // wrapping back to channel 0 after CHANNEL_COUNT-1.
  always_comb begin
    int scan_ch;
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_ch     = 0;
    for (int k = 0; k < CHANNEL_COUNT; k++) begin
      scan_ch = int'(priority_ptr) + k;
      if (scan_ch >= CHANNEL_COUNT) begin
        scan_ch = scan_ch - CHANNEL_COUNT;
      end
      if (!grant_found && bus.input_valid[scan_ch]) begin
        grant_found = 1'b1;
        grant_idx   = scan_ch[CHANNEL_INDEX_WIDTH-1:0];
      end
    end
  end

  assign transfer = grant_found & load_enable & ~clear;

  always_comb begin
    ready_vec = '0;
    if (transfer) begin
      ready_vec[grant_idx] = 1'b1;
    end
  end

  // Priority moves to the channel just after the winner.
  always_comb begin
    next_ptr = '0;
    if (int'(grant_idx) != CHANNEL_COUNT - 1) begin
      next_ptr = grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      priority_ptr  <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
    end else if (load_enable) begin
      if (grant_found) begin
        // Replaces any word being drained this cycle, so no bubble.
        out_valid_q   <= 1'b1;
        out_data_q    <= adjusted[grant_idx];
        out_channel_q <= grant_idx;
        priority_ptr  <= next_ptr;
      end else begin
        // Drained with nothing to replace it: data/channel keep last value.
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.input_ready    = ready_vec;
  assign bus.output_valid   = out_valid_q;
  assign bus.output_data    = out_data_q;
  assign bus.output_channel = out_channel_q;

endmodule

// File: tb/tb_width_adj_arbiter.sv
// tb_width_adj_arbiter
// Directed bench for width_adj_arbiter (8 -> 16 bits, 4 channels, signed
// mask 4'b0101) plus a truncating instance (8 -> 4 bits, all signed).
module tb_width_adj_arbiter;

  localparam logic [3:0] SIGNED_MASK = 4'b0101;

  logic clock;
  logic clear;

  width_adj_arbiter_if #(.CHANNEL_COUNT(4), .WORD_WIDTH_IN(8), .WORD_WIDTH_OUT(16)) bus ();
  width_adj_arbiter_if #(.CHANNEL_COUNT(4), .WORD_WIDTH_IN(8), .WORD_WIDTH_OUT(4))  tbus ();

  width_adj_arbiter #(
    .WORD_WIDTH_IN(8), .WORD_WIDTH_OUT(16), .CHANNEL_COUNT(4), .CHANNEL_SIGNED(SIGNED_MASK)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  width_adj_arbiter #(
    .WORD_WIDTH_IN(8), .WORD_WIDTH_OUT(4), .CHANNEL_COUNT(4), .CHANNEL_SIGNED(4'b1111)
  ) dut_trunc (
    .clock (clock),
    .clear (clear),
    .bus   (tbus)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- counters / check ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Model state: what the output register must hold, and who has priority.
  logic        m_valid;
  logic [15:0] m_data;
  int          m_chan;
  int          m_ptr;
  bit          live = 1'b0;
  logic [17:0] exp_q[$];   // {channel[1:0], data[15:0]} awaiting consumption

  function automatic logic [15:0] model_adj(input int ch, input logic [7:0] v);
    logic [3:0] mask;
    int x;
    mask = SIGNED_MASK;
    x = int'(v);
    if (mask[ch] && x >= 128) x = x - 256;
    return 16'(x);
  endfunction

  function automatic int model_grant(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clock) begin
    int g;
    live <= 1'b1;
    if (clear) begin
      m_valid = 1'b0;
      m_data  = 16'h0;
      m_chan  = 0;
      m_ptr   = 0;
      exp_q.delete();
    end else if (!m_valid || bus.output_ready) begin
      g = model_grant(bus.input_valid, m_ptr);
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = model_adj(g, bus.input_data[g*8 +: 8]);
        m_chan  = g;
        m_ptr   = (g + 1) % 4;
        exp_q.push_back({g[1:0], m_data});
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare process: mid-cycle, inputs and outputs are settled.
  always @(negedge clock) begin
    logic [3:0]  exp_ready;
    logic [17:0] e;
    int g;
    if (live) begin
      exp_ready = 4'b0000;
      g = model_grant(bus.input_valid, m_ptr);
      if (!clear && (!m_valid || bus.output_ready) && g >= 0) exp_ready[g] = 1'b1;
      chk("cyc_input_ready", bus.input_ready, exp_ready);
      chk("cyc_output_valid", bus.output_valid, m_valid);
      chk("cyc_output_data", bus.output_data, m_data);
      chk("cyc_output_channel", bus.output_channel, m_chan[1:0]);
      if (bus.output_valid && bus.output_ready && !clear) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", bus.output_data, e[15:0]);
          chk("sb_channel", bus.output_channel, e[17:16]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [7:0] d);
    bus.input_valid[ch]     = v;
    bus.input_data[ch*8 +: 8] = d;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [15:0] d, input logic [1:0] c);
    chk({name, "_valid"}, bus.output_valid, v);
    chk({name, "_data"}, bus.output_data, d);
    chk({name, "_channel"}, bus.output_channel, c);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] rr_exp [4];

  initial begin
    rr_exp = '{16'hFFF0, 16'h0091, 16'h0022, 16'h00B3};

    clear              = 1'b1;
    bus.input_valid    = 4'hF;
    bus.input_data     = 32'hDEAD_BEEF;
    bus.output_ready   = 1'b1;
    tbus.input_valid   = 4'h0;
    tbus.input_data    = 32'h0;
    tbus.output_ready  = 1'b1;

    // Reset: no acceptance while clear is high.
    step();
    chk("reset_ready_0", bus.input_ready, 4'h0);
    step();
    chk("reset_ready_1", bus.input_ready, 4'h0);
    clear           = 1'b0;
    bus.input_valid = 4'h0;
    expect_out("reset_out", 1'b0, 16'h0000, 2'd0);

    // Extension per channel signedness.
    set_ch(0, 1'b1, 8'h80); step();
    expect_out("ext_ch0", 1'b1, 16'hFF80, 2'd0);
    set_ch(0, 1'b0, 8'h00); set_ch(1, 1'b1, 8'h80); step();
    expect_out("ext_ch1", 1'b1, 16'h0080, 2'd1);
    set_ch(1, 1'b0, 8'h00); set_ch(2, 1'b1, 8'h7F); step();
    expect_out("ext_ch2", 1'b1, 16'h007F, 2'd2);
    set_ch(2, 1'b0, 8'h00); set_ch(3, 1'b1, 8'hFE); step();
    expect_out("ext_ch3", 1'b1, 16'h00FE, 2'd3);
    set_ch(3, 1'b0, 8'h00);

    // Round robin with all channels valid: 0,1,2,3,0,1,2,3,0.
    bus.input_data  = 32'hB3_22_91_F0;
    bus.input_valid = 4'hF;
    for (int i = 0; i < 9; i++) begin
      step();
      expect_out("rr_seq", 1'b1, rr_exp[i % 4], 2'(i % 4));
    end
    // Pointer now at 1; only channel 3 offers.
    bus.input_valid = 4'b1000; step();
    expect_out("rr_only3", 1'b1, 16'h00B3, 2'd3);
    bus.input_valid = 4'hF; step();
    expect_out("rr_wrap0", 1'b1, 16'hFFF0, 2'd0);

    // Backpressure: hold three cycles, then drain with no bubble.
    bus.input_valid  = 4'h0;
    bus.output_ready = 1'b0;
    set_ch(1, 1'b1, 8'h55);
    set_ch(2, 1'b1, 8'hC4);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("bp_hold", 1'b1, 16'hFFF0, 2'd0);
      chk("bp_ready", bus.input_ready, 4'h0);
    end
    bus.output_ready = 1'b1; step();
    expect_out("bp_rel1", 1'b1, 16'h0055, 2'd1);
    set_ch(1, 1'b0, 8'h00); step();
    expect_out("bp_rel2", 1'b1, 16'hFFC4, 2'd2);
    set_ch(2, 1'b0, 8'h00); step();
    expect_out("bp_empty", 1'b0, 16'hFFC4, 2'd2);

    // Clear mid-stream with a stalled word and pointer at 2.
    set_ch(1, 1'b1, 8'h0A); step();
    expect_out("cm_load", 1'b1, 16'h000A, 2'd1);
    set_ch(1, 1'b0, 8'h00);
    bus.output_ready = 1'b0; step();
    expect_out("cm_stall", 1'b1, 16'h000A, 2'd1);
    clear = 1'b1;
    bus.input_data  = 32'hB3_22_91_F0;
    bus.input_valid = 4'hF; step();
    chk("cm_cleared_valid", bus.output_valid, 1'b0);
    chk("cm_ready_during_clear", bus.input_ready, 4'h0);
    clear = 1'b0;
    bus.output_ready = 1'b1; step();
    expect_out("cm_first_grant", 1'b1, 16'hFFF0, 2'd0);
    bus.input_valid = 4'h0; step();
    chk("cm_drained", bus.output_valid, 1'b0);

    // Truncation instance: keep the low 4 bits.
    tbus.input_valid[0] = 1'b1; tbus.input_data[7:0] = 8'hA5; step();
    chk("trunc_ch0_data", tbus.output_data, 4'h5);
    chk("trunc_ch0_channel", tbus.output_channel, 2'd0);
    chk("trunc_ch0_valid", tbus.output_valid, 1'b1);
    tbus.input_valid[0] = 1'b0;
    tbus.input_valid[1] = 1'b1; tbus.input_data[15:8] = 8'h3C; step();
    chk("trunc_ch1_data", tbus.output_data, 4'hC);
    chk("trunc_ch1_channel", tbus.output_channel, 2'd1);
    tbus.input_valid = 4'h0; step();
    chk("trunc_drained", tbus.output_valid, 1'b0);

    step();
    chk("sb_leftover", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
